// File: rtl/dds_pkg.sv
// Shared definitions for the DDS function generator DAC output path.
// Provides the default DAC width, the output controller state encoding,
// and the helpers that produce the idle code and the two's-complement to
// offset-binary code.
package dds_pkg;

  localparam int DAC_W  = 14;
  localparam int FUNC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } dac_state_t;

  // Code that puts a DAC of width w at its output midpoint: zero for a
  // two's-complement bus, only the MSB set for an offset-binary bus.
  function automatic logic [FUNC_W-1:0] midscale(input int w, input bit offset_bin);
    logic [FUNC_W-1:0] m;
    m = '0;
    if (offset_bin) m = {{(FUNC_W-1){1'b0}}, 1'b1} << (w - 1);
    return m;
  endfunction

  // Two's complement to offset binary is just an inversion of the sign bit
  // of a w-bit value; the upper unused bits pass through unchanged.
  function automatic logic [FUNC_W-1:0] to_offset_bin(input logic [FUNC_W-1:0] x,
                                                      input int w);
    return x ^ ({{(FUNC_W-1){1'b0}}, 1'b1} << (w - 1));
  endfunction

endpackage

// File: rtl/dac_out_ctrl_if.sv
// Sample stream between the DDS amplitude pipeline and the DAC output
// controller.
//   s_data  : two's-complement sample, DATA_W bits
//   s_valid : s_data holds a sample
//   s_ready : the consumer can take a sample this cycle
// master = sample producer (DDS core), slave = consumer (dac_out_ctrl).
interface dac_out_ctrl_if #(
  parameter int DATA_W = dds_pkg::DAC_W
);
  logic signed [DATA_W-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_out_ctrl_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push       : write wr_data (ignored when full)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop in the same cycle
//   rd_data    : current head, read straight out of the storage registers
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
module sync_fifo
  import dds_pkg::*;
#(
  parameter int WIDTH = DAC_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the level register defines what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dac_out_ctrl.sv
// DAC output controller: buffers DDS samples in a small FIFO, paces them
// out at half the pll_clk rate, generates the DAC sample clock and flags
// FIFO underruns.
//   pll_clk      : single clock
//   Resetn       : asynchronous active-low reset
//   enable       : streaming enable; low returns to IDLE and flushes
//   s_if         : sample stream in (s_data / s_valid / s_ready)
//   Dac_clk      : registered DAC sample clock, pll_clk / 2, 50% duty
//   dac_data     : registered DAC bus, changes only as Dac_clk falls
//   underrun     : sticky, set when a sample slot found the FIFO empty
//   underrun_clr : clears underrun (a simultaneous set wins)
//   level        : FIFO occupancy after the current edge
module dac_out_ctrl
  import dds_pkg::*;
#(
  parameter int DATA_W     = DAC_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME_LVL  = 2,
  parameter int OFFSET_BIN = 1
) (
  input  logic                        pll_clk,
  input  logic                        Resetn,
  input  logic                        enable,
  dac_out_ctrl_if.slave               s_if,
  output logic                        Dac_clk,
  output logic [DATA_W-1:0]           dac_data,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FUNC_W-1:0] MID_EXT = midscale(DATA_W, OFFSET_BIN != 0);
  localparam logic [DATA_W-1:0] MID     = MID_EXT[DATA_W-1:0];
  localparam logic [LW-1:0]     PRIME_L = LW'(PRIME_LVL);

  dac_state_t        state_q, state_d;
  logic              ph_q, ph_d;
  logic              dac_clk_q, dac_clk_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [LW-1:0]     fifo_level;

  logic [FUNC_W-1:0] head_ext, conv_ext;
  logic [DATA_W-1:0] head_conv;

  // s_ready depends on the registered level only, never on s_valid.
  assign s_if.s_ready = !fifo_full;
  assign fifo_push    = s_if.s_valid && !fifo_full;
  // The FIFO is held empty throughout IDLE and on the edge leaving it.
  assign fifo_flush   = !enable || (state_q == IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pll_clk),
    .rst_n   (Resetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (s_if.s_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    head_ext             = '0;
    head_ext[DATA_W-1:0] = fifo_head;
    conv_ext  = (OFFSET_BIN != 0) ? to_offset_bin(head_ext, DATA_W) : head_ext;
    head_conv = conv_ext[DATA_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    dac_clk_d  = dac_clk_q;
    dac_data_d = dac_data_q;
    underrun_d = underrun_q && !underrun_clr;
    fifo_pop   = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      ph_d       = 1'b0;
      dac_clk_d  = 1'b0;
      dac_data_d = MID;
    end else begin
      case (state_q)
        IDLE: begin
          ph_d       = 1'b0;
          dac_clk_d  = 1'b0;
          dac_data_d = MID;
          state_d    = PRIME;
        end
        PRIME: begin
          if (fifo_level >= PRIME_L) begin
            state_d = RUN;
            ph_d    = 1'b0;
          end
        end
        RUN: begin
          if (!ph_q) begin
            // Falling DAC clock edge: the only place new data is launched,
            // giving a full pll_clk of setup and hold around the rise.
            dac_clk_d = 1'b0;
            if (!fifo_empty) begin
              dac_data_d = head_conv;
              fifo_pop   = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
            ph_d = 1'b1;
          end else begin
            dac_clk_d = 1'b1;
            ph_d      = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pll_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      ph_q       <= 1'b0;
      dac_clk_q  <= 1'b0;
      dac_data_q <= MID;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      dac_clk_q  <= dac_clk_d;
      dac_data_q <= dac_data_d;
      underrun_q <= underrun_d;
    end
  end

  assign Dac_clk  = dac_clk_q;
  assign dac_data = dac_data_q;
  assign underrun = underrun_q;
  assign level    = fifo_level;

endmodule

// File: tb/tb_dac_out_ctrl.sv
module tb_dac_out_ctrl;

  localparam int DW = 14;

  logic          pll_clk;
  logic          Resetn;
  logic          enable;
  logic          underrun_clr;
  logic          Dac_clk;
  logic          underrun;
  logic [DW-1:0] dac_data;
  logic [2:0]    level;

  int total = 0;
  int bad   = 0;

  dac_out_ctrl_if #(.DATA_W(DW)) sif ();

  dac_out_ctrl #(
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .PRIME_LVL  (2),
    .OFFSET_BIN (1)
  ) dut (
    .pll_clk      (pll_clk),
    .Resetn       (Resetn),
    .enable       (enable),
    .s_if         (sif),
    .Dac_clk      (Dac_clk),
    .dac_data     (dac_data),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .level        (level)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic push_set(input logic [DW-1:0] v);
    sif.s_valid = 1'b1;
    sif.s_data  = v;
  endtask

  function automatic logic [DW-1:0] ob(input logic [DW-1:0] x);
    return {~x[DW-1], x[DW-2:0]};
  endfunction

  initial begin : seq
    logic       exp_clk  [6];
    logic [13:0] exp_dat [6];
    logic [13:0] q [$];
    logic [13:0] prev;
    logic [13:0] expv;
    int  pushed;
    int  got;
    int  maxlvl;
    bit  saw_full;
    bit  accept;

    Resetn       = 1'b1;
    enable       = 1'b0;
    underrun_clr = 1'b0;
    sif.s_valid  = 1'b0;
    sif.s_data   = '0;

    // ---------------- reset
    #2 Resetn = 1'b0;
    tick();
    tick();
    chk("rst_dac_clk",  Dac_clk, 0);
    chk("rst_dac_data", dac_data, 14'h2000);
    chk("rst_s_ready",  sif.s_ready, 1);
    chk("rst_level",    level, 0);
    chk("rst_underrun", underrun, 0);
    Resetn = 1'b1;

    // ---------------- stream 0x0000, 0x1FFF, 0x2000
    enable = 1'b1;
    tick();                       // IDLE -> PRIME
    chk("str_prime_level", level, 0);
    push_set(14'h0000); tick();
    chk("str_level1", level, 1);
    push_set(14'h1FFF); tick();
    chk("str_level2", level, 2);
    chk("str_prime_clk", Dac_clk, 0);
    chk("str_prime_data", dac_data, 14'h2000);
    push_set(14'h2000); tick();   // PRIME -> RUN
    chk("str_level3", level, 3);
    sif.s_valid = 1'b0;
    exp_clk = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_dat = '{14'h2000, 14'h2000, 14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("str_dac_clk", Dac_clk, exp_clk[i]);
      chk("str_dac_data", dac_data, exp_dat[i]);
    end
    chk("str_no_underrun", underrun, 0);
    chk("str_drained", level, 0);
    tick();                       // phase 0 with empty FIFO
    chk("str_underrun", underrun, 1);
    chk("str_hold", dac_data, 14'h0000);

    enable = 1'b0;
    tick();
    chk("dis_clk", Dac_clk, 0);
    chk("dis_data", dac_data, 14'h2000);
    chk("dis_sticky", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    chk("clr_underrun", underrun, 0);
    underrun_clr = 1'b0;

    // ---------------- underrun
    enable = 1'b1;
    tick();                       // PRIME
    push_set(14'h0010); tick();
    push_set(14'h0020); tick();
    sif.s_valid = 1'b0;
    tick();                       // RUN
    tick();
    chk("ur_first", dac_data, 14'h2010);
    tick();
    tick();
    chk("ur_second", dac_data, 14'h2020);
    chk("ur_not_yet", underrun, 0);
    tick();
    tick();                       // third phase-0 slot
    chk("ur_set", underrun, 1);
    chk("ur_hold", dac_data, 14'h2020);
    push_set(14'h0100); tick();
    chk("ur_push_level", level, 1);
    chk("ur_clk_hi", Dac_clk, 1);
    sif.s_valid = 1'b0;
    tick();
    chk("ur_resume", dac_data, 14'h2100);
    underrun_clr = 1'b1;
    tick();
    chk("ur_cleared", underrun, 0);
    underrun_clr = 1'b0;
    tick();
    chk("ur_reset_again", underrun, 1);
    tick();
    underrun_clr = 1'b1;
    tick();                       // set and clear together
    chk("ur_set_wins", underrun, 1);
    underrun_clr = 1'b0;

    // ---------------- backpressure, 100 samples
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    pushed   = 0;
    got      = 0;
    maxlvl   = 0;
    saw_full = 1'b0;
    prev     = dac_data;
    for (int cyc = 0; cyc < 600 && got < 100; cyc++) begin
      sif.s_valid = (pushed < 100);
      sif.s_data  = 14'(pushed + 1);
      accept = sif.s_valid && sif.s_ready;
      if (accept) begin
        q.push_back(ob(14'(pushed + 1)));
        pushed++;
      end
      tick();
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (level == 3'd4) begin
        saw_full = 1'b1;
        chk("bp_ready_full", sif.s_ready, 0);
      end
      if (dac_data !== prev) begin
        got++;
        expv = (q.size() > 0) ? q.pop_front() : prev;
        chk("bp_sample", dac_data, expv);
        prev = dac_data;
      end
    end
    sif.s_valid = 1'b0;
    chk("bp_count", got, 100);
    chk("bp_maxlvl", maxlvl, 4);
    chk("bp_saw_full", saw_full, 1);

    // ---------------- enable drop with level 3
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();                       // PRIME
    push_set(14'h0111); tick();
    push_set(14'h0222); tick();
    push_set(14'h0333); tick();   // RUN
    push_set(14'h0444); tick();   // push and pop together
    chk("ed_level3", level, 3);
    chk("ed_data", dac_data, 14'h2111);
    sif.s_valid = 1'b0;
    tick();
    chk("ed_clk_hi", Dac_clk, 1);
    enable = 1'b0;
    tick();
    chk("ed_clk", Dac_clk, 0);
    chk("ed_mid", dac_data, 14'h2000);
    chk("ed_flushed", level, 0);
    chk("ed_ready", sif.s_ready, 1);

    enable = 1'b1;
    tick();                       // PRIME
    push_set(14'h0AAA); tick();
    chk("re_level1", level, 1);
    sif.s_valid = 1'b0;
    tick();
    tick();
    chk("re_wait_data", dac_data, 14'h2000);
    chk("re_wait_clk", Dac_clk, 0);
    push_set(14'h1555); tick();
    chk("re_level2", level, 2);
    sif.s_valid = 1'b0;
    tick();                       // RUN
    chk("re_entry_data", dac_data, 14'h2000);
    tick();
    chk("re_first", dac_data, 14'h2AAA);
    chk("re_level_after", level, 1);
    tick();
    chk("re_clk_hi", Dac_clk, 1);

    // ---------------- asynchronous reset between edges
    #2 Resetn = 1'b0;
    #1;
    chk("ar_clk", Dac_clk, 0);
    chk("ar_data", dac_data, 14'h2000);
    chk("ar_level", level, 0);
    chk("ar_ready", sif.s_ready, 1);
    chk("ar_underrun", underrun, 0);
    #2 Resetn = 1'b1;
    tick();                       // IDLE -> PRIME
    chk("ar_restart_level", level, 0);
    push_set(14'h0001); tick();
    push_set(14'h0002); tick();
    sif.s_valid = 1'b0;
    tick();                       // RUN
    chk("ar_restart_mid", dac_data, 14'h2000);
    chk("ar_restart_clk", Dac_clk, 0);
    tick();
    chk("ar_restart_first", dac_data, 14'h2001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
